// File: rtl/median_image_reader_pkg.sv
// Shared types and constants for the median-image raster reader.
package median_image_reader_pkg;

  localparam int ADDR_W = 8;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pixel_byte_packer.sv
// Tracks reads in flight, packs returned pixels LSB-first into bytes and
// presents them on a valid/ready output register with row/frame markers.
module pixel_byte_packer
  import median_image_reader_pkg::*;
#(
  parameter int COLS   = 128,
  parameter int ROWS   = 128,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              issue,
  input  logic              pixel,
  input  logic              ready,
  output logic              credit,
  output logic              sample,
  output logic [BYTE_W-1:0] data,
  output logic              valid,
  output logic              line_end,
  output logic              last,
  output logic              last_accepted,
  output logic              empty
);

  localparam int BYTES_PER_ROW = COLS / BYTE_W;

  logic [RD_LAT-1:0]  flight;
  logic [3:0]         in_flight;
  logic [3:0]         pack_count, pack_count_nxt;
  logic [BYTE_W-1:0]  pack_data, pack_data_nxt;
  logic [4:0]         byte_col;
  logic [ADDR_W-1:0]  byte_row;
  logic               accept, move, row_end, frame_end;

  // Handshake: a byte transfers on any rising edge where valid && ready;
  // data/line_end/last hold while valid is high and ready is low.
  assign accept        = valid && ready;
  assign sample        = flight[RD_LAT-1];
  assign row_end       = (byte_col == 5'(BYTES_PER_ROW - 1));
  assign frame_end     = row_end && (byte_row == ADDR_W'(ROWS - 1));
  assign move          = (pack_count_nxt == 4'd8) && (!valid || accept);
  assign last_accepted = accept && last;
  assign empty         = (pack_count == 4'd0) && (in_flight == 4'd0);

  // An empty output register can absorb one whole byte, so outstanding bits
  // only need bounding to the packer's 8 slots while that register is full.
  assign credit = !valid || ((5'(pack_count) + 5'(in_flight)) < 5'd8);

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + 4'(flight[i]);
  end

  always_comb begin
    pack_data_nxt  = pack_data;
    pack_count_nxt = pack_count;
    if (sample) begin
      pack_data_nxt[pack_count[2:0]] = pixel;
      pack_count_nxt                 = pack_count + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flight     <= '0;
      pack_count <= '0;
      pack_data  <= '0;
      byte_col   <= '0;
      byte_row   <= '0;
      data       <= '0;
      valid      <= 1'b0;
      line_end   <= 1'b0;
      last       <= 1'b0;
    end else if (clear) begin
      flight     <= '0;
      pack_count <= '0;
      pack_data  <= '0;
      byte_col   <= '0;
      byte_row   <= '0;
      valid      <= 1'b0;
    end else begin
      flight <= RD_LAT'({flight, issue});
      if (move) begin
        data       <= pack_data_nxt;
        valid      <= 1'b1;
        line_end   <= row_end;
        last       <= frame_end;
        pack_data  <= '0;
        pack_count <= '0;
        byte_col   <= row_end ? 5'd0 : byte_col + 5'd1;
        byte_row   <= row_end ? byte_row + 8'd1 : byte_row;
      end else begin
        pack_data  <= pack_data_nxt;
        pack_count <= pack_count_nxt;
        if (accept) valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/median_image_reader.sv
// Raster readout of the median-filtered image into a byte stream.
// Optional set-pixel counter enabled by MEDIAN_READER_COUNT_EN.
module median_image_reader
  import median_image_reader_pkg::*;
#(
  parameter int COLS   = 128,
  parameter int ROWS   = 128,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startRead,
  output logic        readMedianImage,
  output logic [7:0]  xAddressOut,
  output logic [7:0]  yAddressOut,
  input  logic        medianDataIn,
  output logic [7:0]  outData,
  output logic        outValid,
  input  logic        outReady,
  output logic        outLineEnd,
  output logic        outLast,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fsm_state
`ifdef MEDIAN_READER_COUNT_EN
  ,
  output logic [15:0] onesCount
`endif
);

  state_t state, state_nxt;
  logic   start, issue, credit, sample, last_accepted, packer_empty, last_addr;

  assign start     = (state == IDLE) && startRead;
  assign issue     = (state == ISSUE) && credit;
  assign last_addr = (xAddressOut == ADDR_W'(COLS - 1)) && (yAddressOut == ADDR_W'(ROWS - 1));
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    readMedianImage = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    case (state)
      IDLE:  if (startRead) state_nxt = ISSUE;
      ISSUE: begin
        readMedianImage = 1'b1;
        busy            = 1'b1;
        if (issue && last_addr) state_nxt = DRAIN;
      end
      DRAIN: begin
        readMedianImage = 1'b1;
        busy            = 1'b1;
        if (last_accepted && packer_empty) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The final address is held through DRAIN; it returns to (0,0) after the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xAddressOut <= '0;
      yAddressOut <= '0;
    end else if (start || state == DONE) begin
      xAddressOut <= '0;
      yAddressOut <= '0;
    end else if (issue && !last_addr) begin
      if (xAddressOut == ADDR_W'(COLS - 1)) begin
        xAddressOut <= '0;
        yAddressOut <= yAddressOut + 8'd1;
      end else begin
        xAddressOut <= xAddressOut + 8'd1;
      end
    end
  end

  pixel_byte_packer #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .RD_LAT (RD_LAT)
  ) u_packer (
    .clk           (clk),
    .reset         (reset),
    .clear         (start),
    .issue         (issue),
    .pixel         (medianDataIn),
    .ready         (outReady),
    .credit        (credit),
    .sample        (sample),
    .data          (outData),
    .valid         (outValid),
    .line_end      (outLineEnd),
    .last          (outLast),
    .last_accepted (last_accepted),
    .empty         (packer_empty)
  );

`ifdef MEDIAN_READER_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                             onesCount <= '0;
    else if (start)                                        onesCount <= '0;
    else if (sample && medianDataIn && onesCount != 16'hFFFF) onesCount <= onesCount + 16'd1;
  end
`else
  logic unused_sample;
  assign unused_sample = sample;
`endif

endmodule

// File: tb/tb_median_image_reader.sv
// Scoreboard bench for median_image_reader on a 16x4 frame (8 bytes).
module tb_median_image_reader;

  localparam int COLS = 16;
  localparam int ROWS = 4;
  localparam int NBYTES = COLS * ROWS / 8;

  logic        clk = 1'b0;
  logic        reset, startRead, medianDataIn, outReady;
  logic        readMedianImage, outValid, outLineEnd, outLast, busy, done;
  logic [7:0]  xAddressOut, yAddressOut, outData;
  logic [1:0]  fsm_state;
`ifdef MEDIAN_READER_COUNT_EN
  logic [15:0] onesCount;
`endif

  logic [9:0]  exp_q[$];
  logic [7:0]  frame [NBYTES];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          frame_bytes = 0;
  logic        rate_chk = 1'b0;
  logic        rand_ready = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  median_image_reader #(.COLS(COLS), .ROWS(ROWS), .RD_LAT(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .startRead       (startRead),
    .readMedianImage (readMedianImage),
    .xAddressOut     (xAddressOut),
    .yAddressOut     (yAddressOut),
    .medianDataIn    (medianDataIn),
    .outData         (outData),
    .outValid        (outValid),
    .outReady        (outReady),
    .outLineEnd      (outLineEnd),
    .outLast         (outLast),
    .busy            (busy),
    .done            (done),
    .fsm_state       (fsm_state)
`ifdef MEDIAN_READER_COUNT_EN
    ,
    .onesCount       (onesCount)
`endif
  );

  // Memory model: address register then synchronous read (2-cycle latency).
  logic [7:0] ax, ay, row_byte;
  assign row_byte = frame[{ay[1:0], ax[3]}];
  always @(posedge clk) begin
    ax <= xAddressOut;
    ay <= yAddressOut;
    medianDataIn <= row_byte[ax[2:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < NBYTES; i++)
      exp_q.push_back({(i == NBYTES - 1), (i % 2 == 1), frame[i]});
  endtask

  task automatic start_frame(output int t);
    push_frame();
    startRead = 1'b1;
    next();
    startRead = 1'b0;
    t = 1;
    check("cycle1_busy_rmi", {busy, readMedianImage}, 2'b11);
    check("cycle1_addr", {yAddressOut, xAddressOut}, 16'h0000);
    while (!outValid && t < 100) begin
      next();
      t++;
    end
    check("first_valid_cycle", t, 11);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 500) begin
      next();
      if (rand_ready) outReady = 1'($urandom_range(0, 1));
      n++;
    end
    check("done_seen", done, 1'b1);
    outReady = 1'b1;
    check("queue_drained", exp_q.size(), 0);
    check("frame_byte_count", frame_bytes, NBYTES);
`ifdef MEDIAN_READER_COUNT_EN
    begin
      int ones = 0;
      for (int i = 0; i < NBYTES; i++) ones += $countones(frame[i]);
      check("ones_count", onesCount, ones);
    end
`endif
    next();
  endtask

  // ---------------- scoreboard monitor ----------------
  logic       prev_stall = 1'b0;
  logic [9:0] prev_out;
  logic       last_hs = 1'b0;
  int         prev_hs_cyc = -1;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      last_hs = 1'b0;
    end else begin
      if (startRead && !busy) begin
        frame_bytes = 0;
        prev_hs_cyc = -1;
      end
      if (last_hs) begin
        check("done_after_last", {done, busy}, 2'b10);
        last_hs = 1'b0;
      end else if (done) begin
        check("spurious_done", done, 1'b0);
      end
      if (outValid) check("rmi_while_valid", readMedianImage, 1'b1);
      if (done) check("rmi_at_done", readMedianImage, 1'b0);
      if (prev_stall)
        check("stall_stable", {outValid, outLast, outLineEnd, outData}, {1'b1, prev_out});
      if (outValid && outReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {outLast, outLineEnd, outData}, 10'h3FF);
        end else begin
          check("byte", {outLast, outLineEnd, outData}, exp_q.pop_front());
        end
        frame_bytes++;
        if (rate_chk && prev_hs_cyc >= 0) check("byte_rate", cyc - prev_hs_cyc, 8);
        prev_hs_cyc = cyc;
        if (outLast) last_hs = 1'b1;
      end
      prev_stall = outValid && !outReady;
      prev_out = {outLast, outLineEnd, outData};
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    logic [15:0] addr_a;
    reset = 1'b1;
    startRead = 1'b0;
    outReady = 1'b1;
    frame = '{8'h55, 8'h55, 8'hAA, 8'hAA, 8'h55, 8'h55, 8'hAA, 8'hAA};
    #12;
    check("rst_rmi", readMedianImage, 1'b0);
    check("rst_addr", {yAddressOut, xAddressOut}, 16'h0000);
    check("rst_outs", {outData, outValid, outLineEnd, outLast}, 11'h000);
    check("rst_busy_done", {busy, done}, 2'b00);
`ifdef MEDIAN_READER_COUNT_EN
    check("rst_ones", onesCount, 16'h0000);
`endif
    next();
    reset = 1'b0;
    next();

    // Checkerboard, ready held high, byte every 8 cycles.
    rate_chk = 1'b1;
    start_frame(t);
    wait_done();

    // All ones.
    frame = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    start_frame(t);
    wait_done();
    rate_chk = 1'b0;

    // Consumer stalls 20 cycles from the first valid byte.
    frame = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'hF0, 8'h0F, 8'h12, 8'h34};
    outReady = 1'b0;
    start_frame(t);
    while (t < 21) begin next(); t++; end
    addr_a = {yAddressOut, xAddressOut};
    while (t < 30) begin next(); t++; end
    check("stall_addr_frozen", {yAddressOut, xAddressOut}, addr_a);
    check("stall_addr_value", {yAddressOut, xAddressOut}, 16'h0100);
    check("stall_valid_held", outValid, 1'b1);
    outReady = 1'b1;
    wait_done();

    // Start pulse while busy is ignored.
    frame = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h81, 8'h7E, 8'h5A};
    start_frame(t);
    repeat (10) next();
    startRead = 1'b1;
    next();
    startRead = 1'b0;
    wait_done();

    // Reset mid-frame inside byte 5, then clean restart.
    start_frame(t);
    while (t < 47) begin next(); t++; end
    reset = 1'b1;
    #1;
    check("midrst_rmi_busy_done", {readMedianImage, busy, done}, 3'b000);
    check("midrst_addr", {yAddressOut, xAddressOut}, 16'h0000);
    check("midrst_outs", {outData, outValid, outLineEnd, outLast}, 11'h000);
    exp_q.delete();
    next();
    reset = 1'b0;
    next();
    frame = '{8'h11, 8'h22, 8'h44, 8'h88, 8'hF1, 8'h1F, 8'hC0, 8'h03};
    start_frame(t);
    wait_done();

    // Random backpressure over a random frame.
    for (int i = 0; i < NBYTES; i++) frame[i] = 8'($urandom_range(0, 255));
    rand_ready = 1'b1;
    start_frame(t);
    wait_done();
    rand_ready = 1'b0;

    repeat (3) next();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
